univ_shift_seq: RTL and testbench
=================================

# univ_shift_seq

Parametrised multi-step universal shift register with a built-in shift sequencer and a START/BUSY/DONE handshake. It replaces single-step S0/S1 control with an operation code and a shift amount. One accepted command shifts, rotates or loads the whole word, one bit per clock, and a serial output reports the last bit shifted out. It sits beside the datapath wherever a normalising or serialising shifter is driven by a control FSM.

## Interface
- C_BIT_NUM, 24: register width (≥2)
- C_AMT_W, 5: shift-amount width; amounts 0..2^C_AMT_W−1 accepted
- CK  in  1  clock, rising edge
- RST  in  1  synchronous active-high reset; one clock; reset is synchronous and active-high
- START  in  1  command strobe; accepted only when BUSY=0
- MODE  in  3  operation: 000 hold, 001 SHL, 010 SHR logical, 011 ASR, 100 ROL, 101 ROR, 110 LOAD, 111 reserved (= hold)
- AMT  in  C_AMT_W  number of single-bit steps
- SLI  in  1  fill bit into Q[0] on SHL
- SRI  in  1  fill bit into Q[C_BIT_NUM−1] on SHR
- D  in  C_BIT_NUM  parallel load data
- Q  out  C_BIT_NUM  register contents
- BUSY  out  1  shift sequence in progress
- DONE  out  1  one-cycle completion pulse
- SO  out  1  last bit shifted or rotated out

## Operation
- States: IDLE and SHIFT. DONE is a registered flag. It is asserted for exactly one cycle on return to IDLE.
- IDLE with START=1: MODE and AMT are latched at that edge. MODE and AMT are don't-care afterwards.
  - LOAD: Q←D at the accepting edge. State stays IDLE. DONE=1 in the following cycle.
  - Hold, reserved, or any shift mode with AMT=0: Q and SO unchanged. DONE=1 in the following cycle.
  - Shift mode with AMT=n>0: count←n, state→SHIFT, BUSY=1.
- Each SHIFT-state edge performs one step. Count decrements. After the step with count=1: state→IDLE, DONE=1 for one cycle.
- Per-step bit rules:
  - SHL: Q[i]←Q[i−1], Q[0]←SLI, SO←old Q[MSB].
  - SHR: Q[i]←Q[i+1], Q[MSB]←SRI, SO←old Q[0].
  - ASR: as SHR, but Q[MSB]←old Q[MSB].
  - ROL: Q[0]←old Q[MSB], SO←old Q[MSB].
  - ROR: Q[MSB]←old Q[0], SO←old Q[0].
- SLI and SRI are sampled live at every step edge, so a serial stream can be fed during the sequence.
- AMT larger than C_BIT_NUM is legal. Steps continue past the full width: shifts fill entirely with the fill bit, rotates wrap.
- START while BUSY=1 is ignored with no queuing. START during the DONE cycle is accepted, because BUSY=0 then.
- SO holds its value between steps and across commands. It changes only on a shift step or on reset.

## Timing
- Reset value (after one RST edge): Q=0, BUSY=0, DONE=0, SO=0, state IDLE, count=0.
- RST overrides START in the same cycle.
- RST mid-sequence aborts the sequence. No DONE pulse is issued.
- Shift command accepted at edge k with AMT=n:
  - BUSY=1 for cycles k+1..k+n.
  - Step j happens at edge k+j.
  - Final Q is visible after edge k+n.
  - DONE=1 during cycle k+n+1 (after edge k+n). BUSY=0 in that cycle.
- Load, hold and zero-step commands have 1-cycle latency: DONE in the cycle after acceptance, and BUSY never asserts.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package univ_shift_pkg holds:
  - the mode_e enum (MODE encodings above)
  - the state_e enum (IDLE, SHIFT)
  - fill-source select constants.
- Sub-module shift_cell: a per-bit 4:1 mux plus flop with synchronous reset. Its inputs are hold, left neighbour, right neighbour and load. The top level generates C_BIT_NUM instances. It owns the end-cell fill muxes (SLI, SRI, sign bit, rotate wrap), the counter and the FSM.

## Test plan
All scenarios use C_BIT_NUM=24.
- Reset: RST=1 with START=1, MODE=LOAD, D=24'hFFFFFF → Q=0, BUSY=0, DONE=0, SO=0.
- Load: MODE=LOAD, D=24'hA55AF0 → Q=A55AF0 after the edge, DONE for 1 cycle, BUSY never high.
- SHL: from A55AF0, MODE=SHL, AMT=4, SLI=1 → BUSY for 4 cycles, Q=55AF0F, SO=0, DONE pulse in the 5th cycle.
- ASR: from A55AF0, MODE=ASR, AMT=8 → Q=FFA55A, SO=1, BUSY for 8 cycles.
- ROR: MODE=ROR, AMT=24, with START pulsed (MODE=LOAD) at step 10 → Q returns to its start value, the START is ignored, DONE appears once after step 24.
- Abort and zero-step:
  - RST asserted at step 3 of an 8-step SHR → Q=0 on the next edge, no DONE.
  - Then MODE=SHL with AMT=0 → DONE in the next cycle, Q and SO unchanged.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Shared types and select encodings for the universal shift sequencer.
// Cell-select and fill-source codes are shared by the top level and shift_cell.
package univ_shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_ASR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_LOAD = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Per-cell 4:1 mux select
    localparam logic [1:0] CELL_HOLD       = 2'd0;
    localparam logic [1:0] CELL_FROM_LOWER = 2'd1;
    localparam logic [1:0] CELL_FROM_UPPER = 2'd2;
    localparam logic [1:0] CELL_LOAD       = 2'd3;

    // Source of the bit entering the end cell
    localparam logic [1:0] FILL_SERIAL = 2'd0;
    localparam logic [1:0] FILL_SIGN   = 2'd1;
    localparam logic [1:0] FILL_WRAP   = 2'd2;

    function automatic logic is_shift_mode(input mode_e m);
        return m inside {MODE_SHL, MODE_SHR, MODE_ASR, MODE_ROL, MODE_ROR};
    endfunction

    function automatic logic moves_left(input mode_e m);
        return (m == MODE_SHL) || (m == MODE_ROL);
    endfunction

endpackage

// File: rtl/univ_shift_seq_shift_cell.sv
// One register bit: 4:1 mux (hold / lower neighbour / upper neighbour / load)
// feeding a flop with synchronous reset.
module shift_cell
    import univ_shift_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] sel,
    input  logic       lower_bit,
    input  logic       upper_bit,
    input  logic       load_bit,
    output logic       q
);

    logic q_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            q_reg <= 1'b0;
        end else begin
            case (sel)
                CELL_FROM_LOWER: q_reg <= lower_bit;
                CELL_FROM_UPPER: q_reg <= upper_bit;
                CELL_LOAD:       q_reg <= load_bit;
                default:         q_reg <= q_reg;
            endcase
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/univ_shift_seq.sv
// Multi-step universal shift register: one accepted command shifts, rotates or
// loads the word one bit per clock, with START/BUSY/DONE handshake.
module univ_shift_seq
    import univ_shift_pkg::*;
#(
    parameter int C_BIT_NUM = 24,
    parameter int C_AMT_W   = 5
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [2:0]           MODE,
    input  logic [C_AMT_W-1:0]   AMT,
    input  logic                 SLI,
    input  logic                 SRI,
    input  logic [C_BIT_NUM-1:0] D,
    output logic [C_BIT_NUM-1:0] Q,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 SO
);

    localparam int MSB = C_BIT_NUM - 1;

    state_e               state_reg, state_next;
    mode_e                mode_reg, mode_next;
    logic [C_AMT_W-1:0]   count_reg, count_next;
    logic                 done_reg, done_next;
    logic                 so_reg, so_next;

    logic [C_BIT_NUM-1:0] q_bus;
    logic [1:0]           cell_sel;
    logic [1:0]           fill_sel;
    logic                 low_fill;
    logic                 high_fill;
    mode_e                mode_in;
    logic                 shift_cmd;
    logic                 last_step;

    assign mode_in   = mode_e'(MODE);
    assign shift_cmd = is_shift_mode(mode_in) && (AMT != '0);
    assign last_step = (count_reg == C_AMT_W'(1));

    // State register
    always_ff @(posedge CK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            mode_reg  <= MODE_HOLD;
            count_reg <= '0;
            done_reg  <= 1'b0;
            so_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            count_reg <= count_next;
            done_reg  <= done_next;
            so_reg    <= so_next;
        end
    end

    // Next-state logic; START outside IDLE is dropped, never queued
    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (START && shift_cmd) begin
                    state_next = ST_SHIFT;
                    mode_next  = mode_in;
                    count_next = AMT;
                end
            end
            ST_SHIFT: begin
                count_next = count_reg - C_AMT_W'(1);
                if (last_step) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        cell_sel  = CELL_HOLD;
        fill_sel  = FILL_SERIAL;
        done_next = 1'b0;
        so_next   = so_reg;
        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    if (mode_in == MODE_LOAD) begin
                        cell_sel = CELL_LOAD;
                    end
                    done_next = !shift_cmd;
                end
            end
            ST_SHIFT: begin
                if (moves_left(mode_reg)) begin
                    cell_sel = CELL_FROM_LOWER;
                    so_next  = q_bus[MSB];
                end else begin
                    cell_sel = CELL_FROM_UPPER;
                    so_next  = q_bus[0];
                end
                case (mode_reg)
                    MODE_ASR:           fill_sel = FILL_SIGN;
                    MODE_ROL, MODE_ROR: fill_sel = FILL_WRAP;
                    default:            fill_sel = FILL_SERIAL;
                endcase
                done_next = last_step;
            end
            default: ;
        endcase
    end

    assign low_fill = (fill_sel == FILL_WRAP) ? q_bus[MSB] : SLI;

    always_comb begin
        case (fill_sel)
            FILL_WRAP: high_fill = q_bus[0];
            FILL_SIGN: high_fill = q_bus[MSB];
            default:   high_fill = SRI;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < C_BIT_NUM; gi++) begin : g_cell
            logic lower_bit;
            logic upper_bit;

            if (gi == 0) begin : g_lo_end
                assign lower_bit = low_fill;
            end else begin : g_lo_mid
                assign lower_bit = q_bus[gi-1];
            end

            if (gi == MSB) begin : g_hi_end
                assign upper_bit = high_fill;
            end else begin : g_hi_mid
                assign upper_bit = q_bus[gi+1];
            end

            shift_cell u_cell (
                .clk       (CK),
                .srst      (RST),
                .sel       (cell_sel),
                .lower_bit (lower_bit),
                .upper_bit (upper_bit),
                .load_bit  (D[gi]),
                .q         (q_bus[gi])
            );
        end
    endgenerate

    assign Q    = q_bus;
    assign BUSY = (state_reg == ST_SHIFT);
    assign DONE = done_reg;
    assign SO   = so_reg;

endmodule

// File: tb/tb_univ_shift_seq.sv
// Directed bench for univ_shift_seq: table of commands with hand-computed
// results plus hand-written reset, mid-sequence START, DONE-cycle START and abort cases.
module tb_univ_shift_seq;

    logic        CK = 1'b0;
    logic        RST, START, SLI, SRI;
    logic [2:0]  MODE;
    logic [4:0]  AMT;
    logic [23:0] D;
    logic [23:0] Q;
    logic        BUSY, DONE, SO;

    int n_cmp = 0;
    int n_err = 0;

    univ_shift_seq #(.C_BIT_NUM(24), .C_AMT_W(5)) dut (
        .CK(CK), .RST(RST), .START(START), .MODE(MODE), .AMT(AMT),
        .SLI(SLI), .SRI(SRI), .D(D), .Q(Q), .BUSY(BUSY), .DONE(DONE), .SO(SO)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic [2:0]  mode;
        logic [4:0]  amt;
        logic        sli;
        logic        sri;
        logic [23:0] d;
        logic [23:0] exp_q;
        logic        exp_so;
        int          exp_busy;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command and follow it to DONE; checks latency, BUSY span, Q, SO
    task automatic run_cmd(input string name, input logic [2:0] mode, input logic [4:0] amt,
                           input logic sli, input logic sri, input logic [23:0] d,
                           input logic [23:0] exp_q, input logic exp_so, input int exp_busy);
        int busy_cnt;
        int lat;
        bit seen;
        @(negedge CK);
        START = 1'b1; MODE = mode; AMT = amt; SLI = sli; SRI = sri; D = d;
        @(posedge CK); #1;
        START = 1'b0;
        busy_cnt = 0; lat = 0; seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (DONE) begin
                seen = 1;
                break;
            end
            if (BUSY) busy_cnt++;
            lat++;
            @(posedge CK); #1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(exp_busy));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({name, "_busy_at_done"}, 32'(BUSY), 32'd0);
        check({name, "_q"}, 32'(Q), 32'(exp_q));
        check({name, "_so"}, 32'(SO), 32'(exp_so));
        $display("cmd %s mode=%0d amt=%0d q=%06h so=%0b busy=%0d", name, mode, amt, Q, SO, busy_cnt);
        @(posedge CK); #1;
        check({name, "_done_one_cycle"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;

        vecs[0]  = '{3'b110, 5'd0,  1'b0, 1'b0, 24'hA55AF0, 24'hA55AF0, 1'b0, 0};
        vecs[1]  = '{3'b001, 5'd4,  1'b1, 1'b0, 24'h000000, 24'h55AF0F, 1'b0, 4};
        vecs[2]  = '{3'b110, 5'd0,  1'b0, 1'b0, 24'hA55AF0, 24'hA55AF0, 1'b0, 0};
        vecs[3]  = '{3'b011, 5'd8,  1'b0, 1'b0, 24'h000000, 24'hFFA55A, 1'b1, 8};
        vecs[4]  = '{3'b010, 5'd4,  1'b0, 1'b0, 24'h000000, 24'h0FFA55, 1'b1, 4};
        vecs[5]  = '{3'b100, 5'd4,  1'b0, 1'b0, 24'h000000, 24'hFFA550, 1'b0, 4};
        vecs[6]  = '{3'b000, 5'd5,  1'b1, 1'b1, 24'h123456, 24'hFFA550, 1'b0, 0};
        vecs[7]  = '{3'b111, 5'd3,  1'b1, 1'b1, 24'h123456, 24'hFFA550, 1'b0, 0};
        vecs[8]  = '{3'b001, 5'd0,  1'b1, 1'b1, 24'h123456, 24'hFFA550, 1'b0, 0};
        vecs[9]  = '{3'b010, 5'd30, 1'b0, 1'b1, 24'h000000, 24'hFFFFFF, 1'b1, 30};
        vecs[10] = '{3'b001, 5'd25, 1'b0, 1'b1, 24'h000000, 24'h000000, 1'b0, 25};
        vecs[11] = '{3'b110, 5'd9,  1'b0, 1'b0, 24'h800001, 24'h800001, 1'b0, 0};
        vecs[12] = '{3'b100, 5'd31, 1'b0, 1'b0, 24'h000000, 24'h0000C0, 1'b0, 31};
        vecs[13] = '{3'b101, 5'd7,  1'b0, 1'b0, 24'h000000, 24'h800001, 1'b1, 7};
        vecs[14] = '{3'b011, 5'd1,  1'b0, 1'b0, 24'h000000, 24'hC00000, 1'b1, 1};

        // Reset overrides a simultaneous LOAD command
        RST = 1'b1; START = 1'b1; MODE = 3'b110; AMT = '0; SLI = 1'b0; SRI = 1'b0; D = 24'hFFFFFF;
        @(posedge CK); @(posedge CK); #1;
        check("reset_q", 32'(Q), 32'h0);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_so", 32'(SO), 32'd0);
        $display("reset q=%06h busy=%0b done=%0b so=%0b", Q, BUSY, DONE, SO);
        @(negedge CK);
        RST = 1'b0; START = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].mode, vecs[i].amt, vecs[i].sli, vecs[i].sri,
                    vecs[i].d, vecs[i].exp_q, vecs[i].exp_so, vecs[i].exp_busy);
        end

        // ROR by full width with an ignored LOAD strobe at step 10
        run_cmd("ror_preload", 3'b110, 5'd0, 1'b0, 1'b0, 24'hA55AF0, 24'hA55AF0, 1'b1, 0);
        @(negedge CK);
        START = 1'b1; MODE = 3'b101; AMT = 5'd24;
        @(posedge CK); #1;
        START = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        for (int c = 1; c <= 32; c++) begin
            if (DONE) begin
                done_cnt++;
                done_at = c;
            end
            if (BUSY) busy_cnt++;
            if (c == 10) begin
                START = 1'b1; MODE = 3'b110; D = 24'h123456;
            end
            if (c == 11) START = 1'b0;
            @(posedge CK); #1;
        end
        check("ror24_done_count", 32'(done_cnt), 32'd1);
        check("ror24_done_at", 32'(done_at), 32'd25);
        check("ror24_busy_cycles", 32'(busy_cnt), 32'd24);
        check("ror24_q", 32'(Q), 32'hA55AF0);
        check("ror24_so", 32'(SO), 32'd1);
        $display("cmd ror24 q=%06h so=%0b busy=%0d dones=%0d", Q, SO, busy_cnt, done_cnt);

        // START in the DONE cycle is accepted
        @(negedge CK);
        START = 1'b1; MODE = 3'b001; AMT = 5'd2; SLI = 1'b0;
        @(posedge CK); #1;
        START = 1'b0;
        done_at = 0;
        for (int c = 1; c <= 10; c++) begin
            if (DONE) begin
                done_at = c;
                break;
            end
            @(posedge CK); #1;
        end
        check("shl2_done_at", 32'(done_at), 32'd3);
        check("shl2_q", 32'(Q), 32'h956BC0);
        check("shl2_so", 32'(SO), 32'd0);
        START = 1'b1; MODE = 3'b110; D = 24'h123456;
        @(posedge CK); #1;
        START = 1'b0;
        check("done_cycle_load_q", 32'(Q), 32'h123456);
        check("done_cycle_load_done", 32'(DONE), 32'd1);
        $display("cmd load_in_done_cycle q=%06h done=%0b", Q, DONE);

        // Reset at step 3 of an 8-step SHR aborts without DONE
        run_cmd("abort_preload", 3'b110, 5'd0, 1'b0, 1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 0);
        @(negedge CK);
        START = 1'b1; MODE = 3'b010; AMT = 5'd8; SRI = 1'b1;
        @(posedge CK); #1;
        START = 1'b0;
        @(posedge CK); #1;
        @(posedge CK); #1;
        check("abort_so_before", 32'(SO), 32'd1);
        RST = 1'b1;
        @(posedge CK); #1;
        RST = 1'b0;
        check("abort_q", 32'(Q), 32'h0);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_so", 32'(SO), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (DONE) done_cnt++;
            @(posedge CK); #1;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        $display("cmd abort q=%06h busy=%0b dones=%0d", Q, BUSY, done_cnt);

        run_cmd("shl_zero", 3'b001, 5'd0, 1'b1, 1'b1, 24'hABCDEF, 24'h000000, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
